// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// operand-match helper.
package pipeline_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazState_t;

    localparam logic [4:0] ZERO_REG            = 5'd0;
    localparam int         MEM_TIMEOUT_DEFAULT = 255;
    localparam int         WAIT_CNT_W          = 8;

    // One bundle for every pipeline-register control so priority resolution
    // can clear them all with a single default.
    typedef struct packed {
        logic pcStall;
        logic ifidStall;
        logic idexStall;
        logic exmemStall;
        logic ifidFlush;
        logic idexFlush;
        logic memwbFlush;
        logic memTimeout;
    } pipeCtrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: decode/execute/memory status from the pipeline and
// the stall/flush controls returned to it.
interface pipeline_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_branch;
    logic       id_jump_reg;
    logic       id_jump;
    logic       branch_taken;
    logic       ex_memread;
    logic       ex_regwr;
    logic [4:0] ex_rd;
    logic       mem_memread;
    logic [4:0] mem_rd;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_stall;
    logic       ifid_stall;
    logic       idex_stall;
    logic       exmem_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       memwb_flush;
    logic       mem_timeout;

    // master is the pipeline datapath, slave is the hazard controller
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_jump_reg,
               id_jump, branch_taken, ex_memread, ex_regwr, ex_rd,
               mem_memread, mem_rd, mem_req, mem_ready,
        input  pc_stall, ifid_stall, idex_stall, exmem_stall,
               ifid_flush, idex_flush, memwb_flush, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_jump_reg,
               id_jump, branch_taken, ex_memread, ex_regwr, ex_rd,
               mem_memread, mem_rd, mem_req, mem_ready,
        output pc_stall, ifid_stall, idex_stall, exmem_stall,
               ifid_flush, idex_flush, memwb_flush, mem_timeout
    );

endinterface

// File: rtl/hazard_cmp.sv
// Combinational check of both ID source operands against one pipeline
// destination; register zero never matches.
module hazard_cmp
    import pipeline_pkg::*;
(
    input  logic [4:0] srcA,
    input  logic       useA,
    input  logic [4:0] srcB,
    input  logic       useB,
    input  logic [4:0] dstReg,
    input  logic       dstValid,
    output logic       hit
);

    logic dstLive;
    logic matchA;
    logic matchB;

    assign dstLive = dstValid && (dstReg != ZERO_REG);
    assign matchA  = useA && (srcA == dstReg);
    assign matchB  = useB && (srcB == dstReg);
    assign hit     = dstLive && (matchA || matchB);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, load-use and
// ID-resolve stalls, control flushes. Optional stall counter: HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : gBadTimeout
        $error("MEM_TIMEOUT must lie in 1..255");
    end
    if (CNT_W < 1) begin : gBadCntW
        $error("CNT_W must be at least 1");
    end

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    hazState_t             state;
    hazState_t             nextState;
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic [WAIT_CNT_W-1:0] nextWaitCnt;
    pipeCtrl_t             ctrl;

    logic exLoadHit;
    logic exAluHit;
    logic memLoadHit;
    logic resolvesInId;
    logic dataHazard;
    logic ctrlFlush;
    logic memWait;
    logic timeoutHit;

    hazard_cmp uExLoad (
        .srcA    (hz.id_rs),
        .useA    (hz.id_use_rs),
        .srcB    (hz.id_rt),
        .useB    (hz.id_use_rt),
        .dstReg  (hz.ex_rd),
        .dstValid(hz.ex_memread),
        .hit     (exLoadHit)
    );

    hazard_cmp uExAlu (
        .srcA    (hz.id_rs),
        .useA    (hz.id_use_rs),
        .srcB    (hz.id_rt),
        .useB    (hz.id_use_rt),
        .dstReg  (hz.ex_rd),
        .dstValid(hz.ex_regwr),
        .hit     (exAluHit)
    );

    hazard_cmp uMemLoad (
        .srcA    (hz.id_rs),
        .useA    (hz.id_use_rs),
        .srcB    (hz.id_rt),
        .useB    (hz.id_use_rt),
        .dstReg  (hz.mem_rd),
        .dstValid(hz.mem_memread),
        .hit     (memLoadHit)
    );

    // Branches and register jumps compare in ID, so they cannot use forwarding
    // from an ALU result in EX or a load still in MEM.
    assign resolvesInId = hz.id_branch || hz.id_jump_reg;
    assign dataHazard   = exLoadHit || (resolvesInId && (exAluHit || memLoadHit));
    assign ctrlFlush    = hz.id_jump || (hz.id_branch && hz.branch_taken);
    assign memWait      = !hz.mem_ready && ((state == MEM_WAIT) || hz.mem_req);
    assign timeoutHit   = (state == MEM_WAIT) && !hz.mem_ready && (waitCnt == TIMEOUT_VAL);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            RUN:      if (hz.mem_req && !hz.mem_ready) nextState = MEM_WAIT;
            MEM_WAIT: if (hz.mem_ready || waitCnt == TIMEOUT_VAL) nextState = RUN;
            default:  nextState = RUN;
        endcase
    end

    // The count seen during a MEM_WAIT cycle is that cycle's ordinal, so the
    // Nth waiting cycle compares N against MEM_TIMEOUT.
    always_comb begin
        nextWaitCnt = '0;
        if (nextState == MEM_WAIT) begin
            if (state == RUN) begin
                nextWaitCnt = WAIT_CNT_W'(1);
            end else if (waitCnt != TIMEOUT_VAL) begin
                nextWaitCnt = waitCnt + WAIT_CNT_W'(1);
            end else begin
                nextWaitCnt = waitCnt;
            end
        end
    end

    // Priority: reset, timeout abort, memory wait, data stall, control flush.
    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl.ifidFlush  = 1'b1;
            ctrl.idexFlush  = 1'b1;
            ctrl.memwbFlush = 1'b1;
        end else if (timeoutHit) begin
            ctrl.memTimeout = 1'b1;
            ctrl.memwbFlush = 1'b1;
        end else if (memWait) begin
            ctrl.pcStall    = 1'b1;
            ctrl.ifidStall  = 1'b1;
            ctrl.idexStall  = 1'b1;
            ctrl.exmemStall = 1'b1;
            ctrl.memwbFlush = 1'b1;
        end else if (dataHazard) begin
            ctrl.pcStall    = 1'b1;
            ctrl.ifidStall  = 1'b1;
            ctrl.idexFlush  = 1'b1;
        end else if (ctrlFlush) begin
            ctrl.ifidFlush  = 1'b1;
        end
    end

    assign hz.pc_stall    = ctrl.pcStall;
    assign hz.ifid_stall  = ctrl.ifidStall;
    assign hz.idex_stall  = ctrl.idexStall;
    assign hz.exmem_stall = ctrl.exmemStall;
    assign hz.ifid_flush  = ctrl.ifidFlush;
    assign hz.idex_flush  = ctrl.idexFlush;
    assign hz.memwb_flush = ctrl.memwbFlush;
    assign hz.mem_timeout = ctrl.memTimeout;

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (ctrl.pcStall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4); builds with or
// without HAZARD_STALL_CNT_EN.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    // {pc, ifid, idex, exmem stall, ifid, idex, memwb flush, mem_timeout}
    localparam logic [7:0] V_NONE  = 8'b0000_0000;
    localparam logic [7:0] V_STALL = 8'b1100_0100;
    localparam logic [7:0] V_MEM   = 8'b1111_0010;
    localparam logic [7:0] V_CF    = 8'b0000_1000;
    localparam logic [7:0] V_RST   = 8'b0000_1110;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic       useRs;
        logic [4:0] rt;
        logic       useRt;
        logic       branch;
        logic       jumpReg;
        logic       jump;
        logic       taken;
        logic       exMemread;
        logic       exRegwr;
        logic [4:0] exRd;
        logic       memMemread;
        logic [4:0] memRd;
        logic [7:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {hz.pc_stall, hz.ifid_stall, hz.idex_stall, hz.exmem_stall,
                hz.ifid_flush, hz.idex_flush, hz.memwb_flush, hz.mem_timeout};
    endfunction

    task automatic applyVec(input vec_t v);
        hz.id_rs        = v.rs;
        hz.id_use_rs    = v.useRs;
        hz.id_rt        = v.rt;
        hz.id_use_rt    = v.useRt;
        hz.id_branch    = v.branch;
        hz.id_jump_reg  = v.jumpReg;
        hz.id_jump      = v.jump;
        hz.branch_taken = v.taken;
        hz.ex_memread   = v.exMemread;
        hz.ex_regwr     = v.exRegwr;
        hz.ex_rd        = v.exRd;
        hz.mem_memread  = v.memMemread;
        hz.mem_rd       = v.memRd;
    endtask

    task automatic idle();
        applyVec('{"idle", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 5'd0, 1'b0, 5'd0, V_NONE});
        hz.mem_req   = 1'b0;
        hz.mem_ready = 1'b0;
    endtask

    task automatic loadUse();
        applyVec('{"lu", 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b1, 5'd8, 1'b0, 5'd0, V_STALL});
    endtask

    // Inputs change 1 time unit after a rising edge and are checked 2 later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runTable(input vec_t tbl[]);
        foreach (tbl[i]) begin
            applyVec(tbl[i]);
            #2;
            checks++;
            if (obs() !== tbl[i].exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", tbl[i].name, obs(), tbl[i].exp);
            end
            nextCycle();
        end
    endtask

    task automatic test_reset();
        idle();
        hz.mem_req = 1'b1;
        loadUse();
        #2;
        checks++;
        if (obs() !== V_RST) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), V_RST);
        end
`ifdef HAZARD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
        nextCycle();
        reset = 1'b0;
        idle();
        #2;
        checks++;
        if (obs() !== V_NONE) begin
            errors++;
            $display("FAIL reset_release_run: got %b expected %b", obs(), V_NONE);
        end
        nextCycle();
    endtask

    task automatic test_load_use();
        vec_t tbl[] = '{
            '{"lu_rs",      5'd8,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0, V_STALL},
            '{"lu_bubble",  5'd8,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd8, V_NONE},
            '{"lu_rd0",     5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0, V_NONE},
            '{"lu_rt",      5'd3,  1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0, V_STALL},
            '{"lu_unused",  5'd8,  1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0, V_NONE},
            '{"lu_mem_fwd", 5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd7, V_NONE}
        };
        runTable(tbl);
    endtask

    task automatic test_branch_resolve();
        vec_t tbl[] = '{
            '{"br_alu",       5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, V_STALL},
            '{"br_resolved",  5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, V_CF},
            '{"jr_mem_load",  5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, V_STALL},
            '{"br_not_taken", 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, V_NONE},
            '{"jump",         5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, V_CF},
            '{"alu_nobranch", 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, V_NONE},
            '{"br_reg0",      5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, V_CF},
            '{"jr_ex_alu",    5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, V_STALL}
        };
        runTable(tbl);
    endtask

    task automatic test_mem_wait();
        idle();
        for (int c = 0; c < 3; c++) begin
            hz.mem_req = 1'b1;
            loadUse();
            hz.id_jump = 1'b1;
            #2;
            checks++;
            if (obs() !== V_MEM) begin
                errors++;
                $display("FAIL mem_wait_cycle%0d: got %b expected %b", c, obs(), V_MEM);
            end
            nextCycle();
        end
        idle();
        hz.mem_req   = 1'b1;
        hz.mem_ready = 1'b1;
        #2;
        checks++;
        if (obs() !== V_NONE) begin
            errors++;
            $display("FAIL mem_ready_release: got %b expected %b", obs(), V_NONE);
        end
        nextCycle();
        idle();
        #2;
        checks++;
        if (obs() !== V_NONE) begin
            errors++;
            $display("FAIL mem_back_to_run: got %b expected %b", obs(), V_NONE);
        end
        nextCycle();
    endtask

    task automatic test_timeout();
        logic [7:0] o;
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            hz.mem_req = 1'b1;
            // RUN cycle that enters the wait, then MEM_WAIT cycles 1..3
            for (int c = 0; c < 4; c++) begin
                #2;
                checks++;
                if (obs() !== V_MEM) begin
                    errors++;
                    $display("FAIL to%0d_wait%0d: got %b expected %b", pass, c, obs(), V_MEM);
                end
                nextCycle();
            end
            hz.mem_ready = (pass == 1);
            #2;
            o = obs();
            if (pass == 0) begin
                checks++;
                if (o[0] !== 1'b1 || o[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_pulse: got timeout=%b memwb_flush=%b expected 1 1", o[0], o[1]);
                end
            end else begin
                checks++;
                if (o !== V_NONE) begin
                    errors++;
                    $display("FAIL timeout_ready_same_cycle: got %b expected %b", o, V_NONE);
                end
            end
            nextCycle();
            idle();
            #2;
            checks++;
            if (obs() !== V_NONE) begin
                errors++;
                $display("FAIL to%0d_after: got %b expected %b", pass, obs(), V_NONE);
            end
            nextCycle();
        end
    endtask

    task automatic test_reset_mid_wait();
        idle();
        hz.mem_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (obs() !== V_MEM) begin
                errors++;
                $display("FAIL rmw_wait%0d: got %b expected %b", c, obs(), V_MEM);
            end
            if (c < 2) nextCycle();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== V_RST) begin
            errors++;
            $display("FAIL rmw_async_reset: got %b expected %b", obs(), V_RST);
        end
`ifdef HAZARD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== '0) begin
            errors++;
            $display("FAIL rmw_stall_cnt_clear: got %0d expected 0", stall_cnt);
        end
`endif
        nextCycle();
        reset = 1'b0;
        idle();
        #2;
        checks++;
        if (obs() !== V_NONE) begin
            errors++;
            $display("FAIL rmw_resume_run: got %b expected %b", obs(), V_NONE);
        end
        nextCycle();
        for (int c = 0; c < 3; c++) begin
            loadUse();
            #2;
            checks++;
            if (obs() !== V_STALL) begin
                errors++;
                $display("FAIL rmw_lu%0d: got %b expected %b", c, obs(), V_STALL);
            end
            nextCycle();
        end
        idle();
        #2;
`ifdef HAZARD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== CNT_W'(3)) begin
            errors++;
            $display("FAIL stall_cnt_count: got %0d expected 3", stall_cnt);
        end
`endif
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_resolve();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
